// File: rtl/alu_seq.sv
// alu_seq -- registered WIDTH-bit ALU with valid/ready handshakes.
//
// Operations (Sel): 000 ADD, 001 AND, 010 SUB, 011 OR, 100 XOR,
//                   101 SHL, 110 SHR (logical), 111 MUL.
//
// Optional feature macro: ALU_MUL_EN
//   defined   -> 111 runs a shift-add multiplier for WIDTH cycles (BUSY state)
//   undefined -> no multiplier and no BUSY state; 111 completes like any
//                other operation with C = C_hi = 0 and err = 1.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   A, B, Sel          operands and operation select (B low bits = shift amount)
//   in_valid/in_ready  operand handshake
//   C, C_hi            result (C_hi = upper half of MUL product, else 0)
//   out_valid/out_ready result handshake
//   Z, N, Cy, V, err   registered status flags
//
// Handshake semantics: a transfer happens on a rising edge where both valid
// and ready are 1. in_ready is 1 only in IDLE and out_valid is 1 only in DONE,
// so an operation is accepted at most once and a result, once presented,
// stays stable until it is consumed. A source must hold in_valid and its
// operands until in_ready is seen; operands are sampled only on the accept
// edge.

module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] C_hi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             Z,
    output logic             N,
    output logic             Cy,
    output logic             V,
    output logic             err
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

    // Current FSM state; kept as a named signal so checkers can bind to it.
    state_t state;
    state_t state_nxt;

    logic             accept;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] res;
    logic             cy_n;
    logic             v_n;
    logic             err_n;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && (state == IDLE);
    assign shamt     = B[SW-1:0];

    // Single-cycle datapath for every operation except a real multiply.
    always_comb begin
        res   = '0;
        cy_n  = 1'b0;
        v_n   = 1'b0;
        err_n = 1'b0;
        sum   = {1'b0, A} + {1'b0, B};
        diff  = {1'b0, A} - {1'b0, B};
        case (Sel)
            OP_ADD: begin
                res  = sum[WIDTH-1:0];
                cy_n = sum[WIDTH];
                // Overflow: operands share a sign the result does not.
                v_n  = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: res = A & B;
            OP_SUB: begin
                res  = diff[WIDTH-1:0];
                // Extended-width MSB of the difference is the borrow (A < B).
                cy_n = diff[WIDTH];
                // Overflow: operand signs differ and result sign differs from A.
                v_n  = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_OR:  res = A | B;
            OP_XOR: res = A ^ B;
            OP_SHL: res = A << shamt;
            OP_SHR: res = A >> shamt;
            OP_MUL: begin
`ifndef ALU_MUL_EN
                err_n = 1'b1;
`endif
                res = '0;
            end
            default: res = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    // Shift-add multiplier: prod holds {partial_hi, remaining multiplier}.
    // Each step conditionally adds the multiplicand to the high half and
    // shifts the whole register right, consuming one multiplier bit.
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH-1:0]   mcand;
    logic [SW-1:0]      cnt;
    logic [WIDTH:0]     padd;
    logic               mul_last;

    always_comb begin
        padd     = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_nxt = {padd, prod[WIDTH-1:1]};
        mul_last = (cnt == SW'(WIDTH - 1));
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
`ifdef ALU_MUL_EN
                    state_nxt = (Sel == OP_MUL) ? BUSY : DONE;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef ALU_MUL_EN
            BUSY: begin
                if (mul_last) state_nxt = DONE;
            end
`endif
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            C     <= '0;
            C_hi  <= '0;
            Z     <= 1'b1;
            N     <= 1'b0;
            Cy    <= 1'b0;
            V     <= 1'b0;
            err   <= 1'b0;
`ifdef ALU_MUL_EN
            prod  <= '0;
            mcand <= '0;
            cnt   <= '0;
`endif
        end else begin
            state <= state_nxt;
`ifdef ALU_MUL_EN
            if (accept && (Sel == OP_MUL)) begin
                prod  <= {{WIDTH{1'b0}}, B};
                mcand <= A;
                cnt   <= '0;
            end else if (accept) begin
`else
            if (accept) begin
`endif
                C    <= res;
                C_hi <= '0;
                Z    <= (res == '0);
                N    <= res[WIDTH-1];
                Cy   <= cy_n;
                V    <= v_n;
                err  <= err_n;
            end
`ifdef ALU_MUL_EN
            if (state == BUSY) begin
                prod <= prod_nxt;
                cnt  <= cnt + SW'(1);
                // Last step: publish the product straight from the adder.
                if (mul_last) begin
                    C    <= prod_nxt[WIDTH-1:0];
                    C_hi <= prod_nxt[2*WIDTH-1:WIDTH];
                    Z    <= (prod_nxt[WIDTH-1:0] == '0);
                    N    <= prod_nxt[WIDTH-1];
                    Cy   <= 1'b0;
                    V    <= (prod_nxt[2*WIDTH-1:WIDTH] != '0);
                    err  <= 1'b0;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH = 4). Builds with or without
// ALU_MUL_EN; the MUL expectations follow the macro.

module tb_alu_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [2:0]   Sel = 3'b000;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic [W-1:0] C;
    logic [W-1:0] C_hi;
    logic         out_valid;
    logic         Z, N, Cy, V, err;

    int n_cmp  = 0;
    int n_fail = 0;
    int lat;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .Sel       (Sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .C         (C),
        .C_hi      (C_hi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Z         (Z),
        .N         (N),
        .Cy        (Cy),
        .V         (V),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic [W-1:0] c, input logic [W-1:0] chi,
                           input logic z, input logic n, input logic cy, input logic v,
                           input logic e);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".C"},    32'(C),    32'(c));
        chk({tag, ".C_hi"}, 32'(C_hi), 32'(chi));
        chk({tag, ".Z"},    32'(Z),    32'(z));
        chk({tag, ".N"},    32'(N),    32'(n));
        chk({tag, ".Cy"},   32'(Cy),   32'(cy));
        chk({tag, ".V"},    32'(V),    32'(v));
        chk({tag, ".err"},  32'(err),  32'(e));
    endtask

    // Present one operation, then scramble the inputs after the accept edge.
    // lat = edges from the accept edge to the first edge that sees out_valid.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] sel,
                         output int l);
        @(negedge clk);
        A = a; B = b; Sel = sel; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; A = ~a; B = ~b; Sel = 3'b001;
        l = 1;
        while (out_valid !== 1'b1 && l < 40) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, ".idle_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".idle_in_ready"},  32'(in_ready),  32'd1);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] c_hold;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready",  32'(in_ready),  32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.C",    32'(C),    32'd0);
        chk("rst.C_hi", 32'(C_hi), 32'd0);
        chk("rst.Z",    32'(Z),    32'd1);
        chk("rst.N",    32'(N),    32'd0);
        chk("rst.Cy",   32'(Cy),   32'd0);
        chk("rst.V",    32'(V),    32'd0);
        chk("rst.err",  32'(err),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD 3+2
        issue(4'b0011, 4'b0010, 3'b000, lat);
        chk("add1.lat", 32'(lat), 32'd1);
        chk_res("add1", 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        consume("add1");

        // AND
        issue(4'b0011, 4'b0010, 3'b001, lat);
        chk_res("and", 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        consume("and");

        // ADD 8+8: wraps to zero with carry and signed overflow
        issue(4'b1000, 4'b1000, 3'b000, lat);
        chk_res("add2", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        consume("add2");

        // SUB 3-5 = -2: borrow, no overflow
        issue(4'b0011, 4'b0101, 3'b010, lat);
        chk_res("sub1", 4'b1110, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        consume("sub1");

        // SUB -8-1: signed overflow, no borrow
        issue(4'b1000, 4'b0001, 3'b010, lat);
        chk_res("sub2", 4'b0111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        consume("sub2");

        // SHL by 1
        issue(4'b1011, 4'b0001, 3'b101, lat);
        chk_res("shl", 4'b0110, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        consume("shl");

        // SHR: B=0101 -> amount 1 (B mod 4)
        issue(4'b1011, 4'b0101, 3'b110, lat);
        chk_res("shr", 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        consume("shr");

        // SHL: B=0111 -> amount 3
        issue(4'b0011, 4'b0111, 3'b101, lat);
        chk_res("shl3", 4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        consume("shl3");

        // XOR and OR
        issue(4'b1100, 4'b1010, 3'b100, lat);
        chk_res("xor", 4'b0110, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        consume("xor");
        issue(4'b1100, 4'b0011, 3'b011, lat);
        chk_res("or", 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        consume("or");

        // MUL 7*6 = 42 = 0010_1010
        issue(4'b0111, 4'b0110, 3'b111, lat);
`ifdef ALU_MUL_EN
        chk("mul.lat", 32'(lat), 32'd5);
        chk_res("mul", 4'b1010, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
`else
        chk("mul.lat", 32'(lat), 32'd1);
        chk_res("mul", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
        consume("mul");

        // Backpressure: result held for 10 cycles while a new request is ignored
        issue(4'b0011, 4'b0010, 3'b000, lat);
        chk_res("bp0", 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            A = 4'(i); B = 4'b1111; Sel = 3'b010; in_valid = 1'b1;
            @(posedge clk); #1;
            chk("bp.C",         32'(C),         32'd5);
            chk("bp.Z",         32'(Z),         32'd0);
            chk("bp.in_ready",  32'(in_ready),  32'd0);
            chk("bp.out_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.rel_out_valid", 32'(out_valid), 32'd0);
        chk("bp.rel_in_ready",  32'(in_ready),  32'd1);
        chk("bp.rel_C",         32'(C),         32'd5);
        @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("bp.no_phantom", 32'(out_valid), 32'd0);

        // Reset during the second BUSY cycle of a MUL
        c_hold = C;
        chk("rstop.pre_C", 32'(c_hold), 32'd5);
        @(negedge clk);
        A = 4'b0111; B = 4'b0110; Sel = 3'b111; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rstop.out_valid", 32'(out_valid), 32'd0);
        chk("rstop.in_ready",  32'(in_ready),  32'd1);
        chk("rstop.C",         32'(C),         32'd0);
        chk("rstop.C_hi",      32'(C_hi),      32'd0);
        chk("rstop.Z",         32'(Z),         32'd1);
        chk("rstop.err",       32'(err),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("rstop.stale", 32'(out_valid), 32'd0);
        end

        // Block works normally after the aborted operation
        issue(4'b0110, 4'b0011, 3'b010, lat);
        chk_res("post", 4'b0011, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        consume("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
